alu_wb_stage: RTL
=================

# alu_wb_stage

Registered result stage directly downstream of the ALU in the enhanced MIPS datapath. It accepts one ALU result per cycle over a valid/ready handshake and buffers up to two results in a two-entry queue. It owns the architectural HI/LO registers and the NZVC status register. It presents the writeback value, selecting among ALU Y_lo, HI and LO, to the register-file write port.

## Interface
- DEPTH, 2, queue entries; fixed, no other value supported
- FS_MUL, 5'h1E, function-select code that writes HI/LO from the multiplier
- FS_DIV, 5'h1F, function-select code that writes HI/LO from the divider
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept; equals (count != 2)
- FS  in  5  function select of the op producing the result
- Y_hi, Y_lo  in  32 each  ALU outputs
- N, Z, V, C  in  1 each  ALU flags; X values are stored as-is
- D_Addr  in  5  destination register
- D_En  in  1  register write enable for the op
- wb_sel  in  2  00 = Y_lo, 01 = HI, 10 = LO, 11 = reserved (treated as 00)
- out_valid  out  1  head entry present
- out_ready  in  1  writeback consumes head
- wb_data  out  32  writeback value of head entry
- wb_addr  out  5  head D_Addr
- wb_en  out  1  head D_En AND out_valid
- hi_q, lo_q  out  32 each  architectural HI/LO
- flags_q  out  4  {N,Z,V,C} of last retired op

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Each entry stores {FS, Y_hi, Y_lo, NZVC, D_Addr, D_En, wb_sel}. Queue is circular: wr_ptr and rd_ptr are 1 bit, count is 0..2.
- Push writes the entry at wr_ptr and toggles wr_ptr. Pop toggles rd_ptr. count += push − pop.
- On pop, when head FS is FS_MUL or FS_DIV: hi_q ← head Y_hi and lo_q ← head Y_lo. Otherwise HI/LO hold.
- On every pop: flags_q ← head NZVC.
- wb_data is combinational from the head entry and the current hi_q/lo_q:
  - wb_sel 01 gives hi_q; 10 gives lo_q; otherwise head Y_lo.
  - HI/LO update at retirement, so an MFHI queued behind a MULT sees the MULT result, because it becomes head only after the MULT pops.
- Empty (count 0): out_valid = 0 and wb_en = 0. wb_data and wb_addr are don't-care.
- Full (count 2): in_ready = 0 and any push is ignored, even with a simultaneous pop. There is no full-queue bypass.
- Push and pop in the same cycle at count 1: count stays 1, both pointers advance.
- Pointer wrap is natural 1-bit overflow.

## Timing
- Reset, synchronous, when reset is high at a clk edge:
  - count, wr_ptr, rd_ptr = 0
  - hi_q, lo_q = 32'h0
  - flags_q = 4'b0
  - out_valid = 0, in_ready = 1 the cycle after
  - Entry storage is not cleared.
- Reset asserted mid-operation discards all queued entries. Pending HI/LO updates in unretired entries are lost. The same-edge push and pop are ignored.
- Latency: a push at edge k makes out_valid high after edge k; the earliest pop is at edge k+1. There is no combinational in-to-out path.
- in_ready depends only on registered count, not on out_ready.
- hi_q, lo_q and flags_q change only at a pop edge, or at reset.
- Throughput: one result per cycle sustained while out_ready = 1.

## Structure
- A shared package `mips_pkg` holds:
  - FS_MUL and FS_DIV constants
  - wb_sel encodings WB_ALU, WB_HI, WB_LO
  - the queue entry struct/width constant
- One sub-module, `result_fifo2`: a generic two-entry valid/ready queue parameterised by entry width. The HI/LO/flags logic and the wb_data mux stay in the top module.

## Test plan
- Reset, then push FS=5'h1E, Y_hi=32'h0000_0001, Y_lo=32'h8000_0000 with out_ready=1 -> out_valid at the next cycle; after the pop, hi_q=32'h1, lo_q=32'h8000_0000.
- Push MULT (Y_hi=32'hA, Y_lo=32'hB), then MFHI (wb_sel=01, D_Addr=5'd3) with out_ready=0; then release out_ready -> the second pop shows wb_data=32'hA, wb_addr=3, wb_en=1.
- Fill with out_ready=0 -> in_ready=0 after two pushes. A third push held with in_valid is not accepted. After one pop, in_ready=1 and the held entry is accepted next.
- At count 1, push and pop every cycle for 8 cycles with Y_lo=0..7 -> data retires in order 0..7, count stays 1, pointers wrap cleanly.
- Push ADD with NZVC=4'b0101 then DIV with Y_hi=32'h3, Y_lo=32'h4 -> after both pops, flags_q equals the DIV entry flags and HI/LO are 3/4. The ADD pop leaves HI/LO at 0.
- Two entries queued, assert reset for 1 cycle -> out_valid=0, in_ready=1, hi_q=lo_q=0, flags_q=0, and the queued MULT never updates HI/LO.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: HI/LO-writing function selects, writeback
// source encodings and the result-queue entry layout.
package mips_pkg;

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_HI  = 2'b01,
    WB_LO  = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [4:0]  fs;
    logic [31:0] y_hi;
    logic [31:0] y_lo;
    logic [3:0]  nzvc;
    logic [4:0]  d_addr;
    logic        d_en;
    logic [1:0]  wb_sel;
  } res_entry_t;

  localparam int ENTRY_W = $bits(res_entry_t);

  function automatic logic writes_hilo(input logic [4:0] fs);
    return (fs == FS_MUL) || (fs == FS_DIV);
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry circular valid/ready queue; data is visible one cycle after the push edge.
// Ready depends only on the registered count; a full queue refuses pushes even on a pop edge.
module result_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_mem [2];
  logic [1:0]   r_count;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  assign o_rdy  = (r_count != 2'd2);
  assign o_vld  = (r_count != 2'd0);
  assign w_push = i_vld & o_rdy;
  assign w_pop  = o_vld & i_rdy;
  assign o_dat  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage is deliberately left uncleared; count alone defines what is live.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU result stage: buffers two results, owns HI/LO and NZVC, drives the register-file write port.
// Output valid one cycle after push; in_ready = queue not full, independent of out_ready.
module alu_wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  FS,
  input  logic [31:0] Y_hi,
  input  logic [31:0] Y_lo,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  input  logic        C,
  input  logic [4:0]  D_Addr,
  input  logic        D_En,
  input  logic [1:0]  wb_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_en,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [3:0]  flags_q
);

  res_entry_t          w_in_entry;
  res_entry_t          w_head;
  logic [ENTRY_W-1:0]  w_head_bits;
  logic                w_out_valid;
  logic                w_pop;
  logic [31:0]         w_wb_data;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [3:0]          r_flags;

  always_comb begin
    w_in_entry        = '0;
    w_in_entry.fs     = FS;
    w_in_entry.y_hi   = Y_hi;
    w_in_entry.y_lo   = Y_lo;
    w_in_entry.nzvc   = {N, Z, V, C};
    w_in_entry.d_addr = D_Addr;
    w_in_entry.d_en   = D_En;
    w_in_entry.wb_sel = wb_sel;
  end

  result_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .i_vld (in_valid),
    .o_rdy (in_ready),
    .i_dat (w_in_entry),
    .o_vld (w_out_valid),
    .i_rdy (out_ready),
    .o_dat (w_head_bits)
  );

  assign w_head = res_entry_t'(w_head_bits);
  assign w_pop  = w_out_valid & out_ready;

  // HI/LO commit at retirement so a later MFHI/MFLO reads the retired value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= 32'h0;
      r_lo    <= 32'h0;
      r_flags <= 4'b0;
    end else if (w_pop) begin
      r_flags <= w_head.nzvc;
      if (writes_hilo(w_head.fs)) begin
        r_hi <= w_head.y_hi;
        r_lo <= w_head.y_lo;
      end
    end
  end

  always_comb begin
    w_wb_data = w_head.y_lo;
    case (w_head.wb_sel)
      WB_HI:   w_wb_data = r_hi;
      WB_LO:   w_wb_data = r_lo;
      default: w_wb_data = w_head.y_lo;
    endcase
  end

  assign out_valid = w_out_valid;
  assign wb_data   = w_wb_data;
  assign wb_addr   = w_head.d_addr;
  assign wb_en     = w_head.d_en & w_out_valid;
  assign hi_q      = r_hi;
  assign lo_q      = r_lo;
  assign flags_q   = r_flags;

endmodule
